simproc_dbg_ctrl: RTL and testbench

Debug host controller for the simproc core: the host side of the core's debug interface (`pc_set_val`/`pc_set_wr`/`run`/`pc_val`/`halt`/`done`). It accepts commands from a host link (UART bridge or JTAG shim) over a valid/ready channel and sequences the core through the commands listed in Operation. After each command it returns one response carrying the final PC. It sits beside simproc in the top level, and its `dbg_*` outputs connect directly to the core's debug inputs.

---
 rtl/simproc_dbg_pkg.sv | 22 ++
 rtl/simproc_dbg_retcnt.sv | 24 ++
 rtl/simproc_dbg_ctrl.sv | 145 ++++++++++++++
 tb/tb_simproc_dbg_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simproc_dbg_pkg.sv
// Shared types for the simproc debug host controller.
package simproc_dbg_pkg;

    typedef enum logic [2:0] {
        CMD_SETPC  = 3'd0,
        CMD_STEP   = 3'd1,
        CMD_RUN    = 3'd2,
        CMD_STOP   = 3'd3,
        CMD_PCREAD = 3'd4
    } dbg_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETPC  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_STEPW  = 3'd3,
        ST_RUNW   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_RESP   = 3'd6
    } dbg_state_t;

endpackage

// File: rtl/simproc_dbg_retcnt.sv
// Saturating retired-instruction counter; clear has priority over increment.
module simproc_dbg_retcnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/simproc_dbg_ctrl.sv
// Debug host controller: sequences simproc through SETPC/STEP/RUN/STOP/PCREAD.
// Define SIMPROC_DBG_RETCNT_EN to build the retired-instruction counter.
//
// state  | meaning
// IDLE   | waiting for a command
// SETPC  | pulse pc_set_wr with the captured argument
// LAUNCH | one-cycle run kick
// STEPW  | stepping; run drops once the last instruction is in flight
// RUNW   | free-running until STOP is accepted
// DRAIN  | run low, waiting for the in-flight instruction to retire
// RESP   | response held until consumed
module simproc_dbg_ctrl
    import simproc_dbg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_op,
    output logic [7:0]       rsp_pc,
    output logic [CNT_W-1:0] rsp_count,
    output logic             busy,
    output logic [7:0]       dbg_pc_set_val,
    output logic             dbg_pc_set_wr,
    output logic             dbg_run,
    input  logic [7:0]       dbg_pc_val,
    input  logic             dbg_halt,
    input  logic             dbg_done
);

    dbg_state_t state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] arg_q;
    logic [2:0] op_q;
    logic [7:0] pc_q;
    logic       resp_seen_q;
    logic       resp_first;
    logic       accept;

    assign accept     = cmd_valid && cmd_ready;
    assign resp_first = (state_q == ST_RESP) && !resp_seen_q;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        cmd_ready     = 1'b0;
        dbg_run       = 1'b0;
        dbg_pc_set_wr = 1'b0;
        rsp_valid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        CMD_SETPC: state_d = ST_SETPC;
                        CMD_STEP: begin
                            if (cmd_arg == 8'd0) begin
                                state_d = ST_RESP;
                            end else begin
                                rem_d   = cmd_arg;
                                state_d = ST_LAUNCH;
                            end
                        end
                        CMD_RUN:  state_d = ST_LAUNCH;
                        default:  state_d = ST_RESP;
                    endcase
                end
            end
            ST_SETPC: begin
                dbg_pc_set_wr = 1'b1;
                state_d       = ST_RESP;
            end
            ST_LAUNCH: begin
                dbg_run = 1'b1;
                state_d = (op_q == CMD_STEP) ? ST_STEPW : ST_RUNW;
            end
            ST_STEPW: begin
                // Dropping run during the last instruction lets the core park itself.
                dbg_run = (rem_q != 8'd1);
                if (dbg_done) begin
                    if (rem_q == 8'd1) state_d = ST_RESP;
                    else               rem_d   = rem_q - 8'd1;
                end
            end
            ST_RUNW: begin
                dbg_run   = 1'b1;
                cmd_ready = (cmd_op == CMD_STOP);
                if (cmd_valid && cmd_ready) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dbg_done || dbg_halt) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            arg_q       <= '0;
            op_q        <= '0;
            pc_q        <= '0;
            resp_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            resp_seen_q <= (state_q == ST_RESP);
            if (accept) begin
                op_q <= cmd_op;
                if (state_q == ST_IDLE) arg_q <= cmd_arg;
            end
            if (resp_first) pc_q <= dbg_pc_val;
        end
    end

    // The PC is shown live on the first RESP cycle so SETPC reports the freshly written value.
    assign rsp_pc         = resp_first ? dbg_pc_val : pc_q;
    assign rsp_op         = op_q;
    assign busy           = (state_q != ST_IDLE);
    assign dbg_pc_set_val = (state_q == ST_SETPC) ? arg_q : 8'd0;

`ifdef SIMPROC_DBG_RETCNT_EN
    simproc_dbg_retcnt #(.CNT_W(CNT_W)) u_retcnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (dbg_done && (state_q != ST_IDLE)),
        .count (rsp_count)
    );
`else
    assign rsp_count = '0;
`endif

endmodule

// File: tb/tb_simproc_dbg_ctrl.sv
// Directed bench for simproc_dbg_ctrl with a small 3-cycle-per-instruction core model.
module tb_simproc_dbg_ctrl;

`ifdef SIMPROC_DBG_RETCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        core_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_op;
    logic [7:0]  rsp_pc;
    logic [15:0] rsp_count;
    logic        busy;
    logic [7:0]  dbg_pc_set_val;
    logic        dbg_pc_set_wr;
    logic        dbg_run;
    logic [7:0]  dbg_pc_val;
    logic        dbg_halt;
    logic        dbg_done;

    int checks = 0;
    int errors = 0;

    simproc_dbg_ctrl #(.CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_op         (rsp_op),
        .rsp_pc         (rsp_pc),
        .rsp_count      (rsp_count),
        .busy           (busy),
        .dbg_pc_set_val (dbg_pc_set_val),
        .dbg_pc_set_wr  (dbg_pc_set_wr),
        .dbg_run        (dbg_run),
        .dbg_pc_val     (dbg_pc_val),
        .dbg_halt       (dbg_halt),
        .dbg_done       (dbg_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: idle (halted) until run, 3 cycles per instruction, done in the last one.
    logic [1:0] cyc;
    logic [7:0] core_pc;
    assign dbg_done   = (cyc == 2'd3);
    assign dbg_halt   = (cyc == 2'd0);
    assign dbg_pc_val = core_pc;

    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            cyc     <= 2'd0;
            core_pc <= 8'd0;
        end else begin
            case (cyc)
                2'd0: begin
                    if (dbg_pc_set_wr) core_pc <= dbg_pc_set_val;
                    else if (dbg_run)  cyc <= 2'd1;
                end
                2'd3: begin
                    core_pc <= core_pc + 8'd1;
                    cyc     <= dbg_run ? 2'd1 : 2'd0;
                end
                default: cyc <= cyc + 2'd1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int  ndone;
    int  extra;
    bit  found;

    initial begin
        rst        = 1'b0;
        core_rst_n = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_arg    = 8'd0;
        rsp_ready  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_rsp_pc", rsp_pc, 0);
        chk("rst_rsp_count", rsp_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dbg_run", dbg_run, 0);
        chk("rst_set_wr", dbg_pc_set_wr, 0);
        chk("rst_set_val", dbg_pc_set_val, 0);

        rst        = 1'b1;
        core_rst_n = 1'b1;
        @(negedge clk);

        // SETPC 0x20
        issue(3'd0, 8'h20);
        chk("setpc_wr_t1", dbg_pc_set_wr, 1);
        chk("setpc_val_t1", dbg_pc_set_val, 8'h20);
        chk("setpc_ready_t1", cmd_ready, 0);
        chk("setpc_rsp_t1", rsp_valid, 0);
        @(negedge clk);
        chk("setpc_wr_t2", dbg_pc_set_wr, 0);
        chk("setpc_rsp_t2", rsp_valid, 1);
        chk("setpc_rsp_pc", rsp_pc, 8'h20);
        chk("setpc_rsp_op", rsp_op, 0);
        chk("setpc_rsp_count", rsp_count, 0);
        consume();
        chk("setpc_done_rsp", rsp_valid, 0);
        chk("setpc_done_ready", cmd_ready, 1);

        // STEP 3 from 0x20
        issue(3'd1, 8'd3);
        chk("step3_launch_run", dbg_run, 1);
        chk("step3_busy", busy, 1);
        ndone = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
            end else if (dbg_done) begin
                ndone++;
                if (ndone == 3) chk("step3_run_low_last_done", dbg_run, 0);
            end
        end
        chk("step3_rsp_seen", found, 1);
        chk("step3_ndone", ndone, 3);
        chk("step3_halt", dbg_halt, 1);
        chk("step3_rsp_pc", rsp_pc, 8'h23);
        chk("step3_rsp_op", rsp_op, 1);
        chk("step3_rsp_count", rsp_count, CNT_ON ? 3 : 0);

        // Back-pressure: hold the STEP 3 response for 10 cycles with a command waiting
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_arg   = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_pc", rsp_pc, 8'h23);
            chk("bp_rsp_op", rsp_op, 1);
            chk("bp_rsp_count", rsp_count, CNT_ON ? 3 : 0);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_set_wr", dbg_pc_set_wr, 0);
        end
        cmd_valid = 1'b0;
        consume();

        // STEP 0
        issue(3'd1, 8'd0);
        chk("step0_run", dbg_run, 0);
        chk("step0_rsp_valid", rsp_valid, 1);
        chk("step0_rsp_pc", rsp_pc, 8'h23);
        chk("step0_rsp_count", rsp_count, 0);
        chk("step0_rsp_op", rsp_op, 1);
        consume();

        // RUN, STOP 20 cycles after accept (not on a done)
        issue(3'd2, 8'd0);
        chk("run_launch_run", dbg_run, 1);
        repeat (19) @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_no_rsp", rsp_valid, 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        #1;
        chk("run_stop_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("drain_run_low", dbg_run, 0);
        extra = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (dbg_done) extra++;
            @(negedge clk);
        end
        chk("stop_rsp_seen", rsp_valid, 1);
        chk("stop_extra_done", extra, 1);
        chk("stop_halt", dbg_halt, 1);
        chk("stop_rsp_op", rsp_op, 3);
        chk("stop_rsp_pc", rsp_pc, 8'h2A);
        consume();

        // RUN, STOP coinciding with a done
        issue(3'd2, 8'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (dbg_done) found = 1'b1;
        end
        chk("coin_done_seen", found, 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        #1;
        chk("coin_stop_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (dbg_done) extra++;
            @(negedge clk);
        end
        chk("coin_rsp_seen", rsp_valid, 1);
        chk("coin_extra_done", extra, 1);
        chk("coin_halt", dbg_halt, 1);
        chk("coin_rsp_op", rsp_op, 3);
        chk("coin_rsp_pc", rsp_pc, 8'h2C);
        consume();

        // Reset during STEPW
        issue(3'd1, 8'd5);
        repeat (5) @(negedge clk);
        chk("rststep_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("rststep_run_now", dbg_run, 0);
        @(negedge clk);
        chk("rststep_run", dbg_run, 0);
        chk("rststep_ready", cmd_ready, 1);
        chk("rststep_rsp", rsp_valid, 0);
        chk("rststep_busy0", busy, 0);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dbg_halt) found = 1'b1;
            else @(negedge clk);
        end
        chk("rststep_core_halt", found, 1);
        chk("rststep_core_pc", dbg_pc_val, 8'h2E);
        repeat (3) @(negedge clk);
        chk("rststep_no_rsp", rsp_valid, 0);
        chk("rststep_halt_stays", dbg_halt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
